// File: rtl/crc8_serial_checker.sv
// Serial CRC-8 (poly 0x9B, init 0x00) frame receiver: DATA_BITS payload bits then 8 CRC bits, MSB first.
// Recomputes the CRC over the payload and flags pass/fail with the recovered payload.
module crc8_serial_checker #(
  parameter int DATA_BITS = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 DIN,
  input  logic                 DIN_VALID,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 CRC_OK,
  output logic                 CRC_ERR,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic [7:0]           CRC_CALC,
  output logic [7:0]           CRC_RX
);
  localparam int CW_RAW = $clog2(DATA_BITS + 1);
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           crc_q, crc_d, rx_q, rx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ok_q, ok_d, err_q, err_d;
  logic                 fb;
  logic [DATA_BITS:0]   data_sh;
  logic [7:0]           rx_sh;

  assign fb      = DIN ^ crc_q[7];
  assign data_sh = {data_q, DIN};
  assign rx_sh   = {rx_q[6:0], DIN};

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DATA, S_CRC: begin
        // START wins over any bit in flight, so an abort restarts cleanly
        if (START) begin
          state_d = S_DATA;
          crc_d   = 8'h00;
          rx_d    = 8'h00;
          cnt_d   = '0;
          ok_d    = 1'b0;
          err_d   = 1'b0;
        end else if (DIN_VALID && state_q == S_DATA) begin
          crc_d  = {crc_q[6] ^ fb, crc_q[5], crc_q[4], crc_q[3] ^ fb,
                    crc_q[2] ^ fb, crc_q[1], crc_q[0] ^ fb, fb};
          data_d = data_sh[DATA_BITS-1:0];
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (DIN_VALID && state_q == S_CRC) begin
          rx_d = rx_sh;
          if (cnt_q == CW'(7)) begin
            cnt_d   = '0;
            state_d = S_DONE;
            // compare against the byte including the bit arriving now
            ok_d    = (rx_sh == crc_q);
            err_d   = (rx_sh != crc_q);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      crc_q   <= 8'h00;
      rx_q    <= 8'h00;
      data_q  <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign BUSY     = (state_q == S_DATA) || (state_q == S_CRC);
  assign DONE     = (state_q == S_DONE);
  assign CRC_OK   = ok_q;
  assign CRC_ERR  = err_q;
  assign DATA_OUT = data_q;
  assign CRC_CALC = crc_q;
  assign CRC_RX   = rx_q;
endmodule

// File: tb/tb_crc8_serial_checker.sv
// Randomized bench for crc8_serial_checker against a long-division CRC-8 reference.
module tb_crc8_serial_checker;
  logic        CLK = 1'b0;
  logic        RST, START, DIN, DIN_VALID;
  logic        BUSY, DONE, CRC_OK, CRC_ERR;
  logic [31:0] DATA_OUT;
  logic [7:0]  CRC_CALC, CRC_RX;

  int errs = 0, checks = 0, dones = 0;

  crc8_serial_checker #(.DATA_BITS(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .BUSY(BUSY), .DONE(DONE), .CRC_OK(CRC_OK), .CRC_ERR(CRC_ERR),
    .DATA_OUT(DATA_OUT), .CRC_CALC(CRC_CALC), .CRC_RX(CRC_RX)
  );

  always #5 CLK = ~CLK;

  // remainder of (payload * x^8) mod 0x19B by polynomial long division
  function automatic logic [7:0] ref_crc(input logic [31:0] p);
    logic [39:0] r;
    r = {p, 8'h00};
    for (int i = 39; i >= 8; i--)
      if (r[i]) r = r ^ (40'h19B << (i - 8));
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (DONE) dones++;
  endtask

  task automatic send_bit(input logic b, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      DIN_VALID = 1'b0;
      DIN       = 1'($urandom);
      step();
      chk("busy_gap", 64'(BUSY), 64'(1));
    end
    DIN_VALID = 1'b1;
    DIN       = b;
    step();
    DIN_VALID = 1'b0;
  endtask

  function automatic int gap_of(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic run_frame(input logic [31:0] pl, input logic [7:0] rxc,
                           input int mode, input bit start_in_done);
    logic [7:0] exp;
    exp       = ref_crc(pl);
    START     = 1'b1;
    DIN       = 1'($urandom);
    DIN_VALID = 1'($urandom);
    step();
    START = 1'b0;
    chk("busy_start", 64'(BUSY), 64'(1));
    chk("ok_clr", 64'({CRC_OK, CRC_ERR}), 64'(0));
    chk("crc_clr", 64'({CRC_CALC, CRC_RX}), 64'(0));
    dones = 0;
    for (int i = 31; i >= 0; i--) begin
      send_bit(pl[i], gap_of(mode));
      chk("crc_live", 64'(CRC_CALC), 64'(ref_crc(pl >> i)));
    end
    for (int i = 7; i >= 0; i--) send_bit(rxc[i], gap_of(mode));
    chk("done_pulse", 64'(DONE), 64'(1));
    chk("done_count", 64'(dones), 64'(1));
    chk("busy_done", 64'(BUSY), 64'(0));
    chk("crc_ok", 64'(CRC_OK), 64'(rxc == exp));
    chk("crc_err", 64'(CRC_ERR), 64'(rxc != exp));
    chk("crc_calc", 64'(CRC_CALC), 64'(exp));
    chk("crc_rx", 64'(CRC_RX), 64'(rxc));
    chk("data_out", 64'(DATA_OUT), 64'(pl));
    START = start_in_done;
    step();
    START = 1'b0;
    chk("done_fall", 64'(DONE), 64'(0));
    chk("busy_idle", 64'(BUSY), 64'(0));
    chk("ok_hold", 64'(CRC_OK), 64'(rxc == exp));
  endtask

  task automatic abort_then(input int n, input logic [31:0] pl, input logic [7:0] rxc);
    START = 1'b1;
    step();
    START = 1'b0;
    dones = 0;
    for (int i = 0; i < n; i++) send_bit(1'($urandom), 0);
    chk("abort_nodone", 64'(dones), 64'(0));
    run_frame(pl, rxc, 0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({BUSY, DONE, CRC_OK, CRC_ERR}), 64'(0));
    chk({tag, "_data"}, 64'(DATA_OUT), 64'(0));
    chk({tag, "_crc"}, 64'({CRC_CALC, CRC_RX}), 64'(0));
  endtask

  initial begin
    logic [31:0] pl;
    logic [7:0]  rc;
    RST = 1'b1; START = 1'b0; DIN = 1'b0; DIN_VALID = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    RST = 1'b0;
    step();

    // mid-frame asynchronous reset after 10 payload bits
    run_frame(32'hFFFF_FFFF, ref_crc(32'hFFFF_FFFF), 0, 1'b0);
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
    RST = 1'b1;
    #1;
    chk_zero("rst_mid");
    step();
    RST = 1'b0;
    chk_zero("rst_rel");
    run_frame(32'h0, 8'h00, 0, 1'b0);

    run_frame(32'h0000_0001, 8'h9B, 0, 1'b0);
    run_frame(32'h0000_0080, 8'h0B, 1, 1'b0);
    run_frame(32'h0000_0001, 8'h9A, 0, 1'b0);
    abort_then(20, 32'h0000_0080, 8'h0B);
    run_frame(32'h0000_0001, 8'h9B, 0, 1'b0);
    run_frame(32'h0000_0080, 8'h0B, 0, 1'b1);

    for (int f = 0; f < 24; f++) begin
      pl = $urandom;
      rc = ref_crc(pl);
      if ($urandom_range(0, 2) == 0) rc = rc ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        abort_then(int'($urandom_range(1, 39)), pl, rc);
      else
        run_frame(pl, rc, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/crc8_serial_checker.md
# crc8_serial_checker

Serial CRC-8 frame receiver and checker for the bit-serial CRC link; it is the receive-side counterpart of the serial CRC-8 generators. The block deserializes a fixed-length frame of DATA_BITS payload bits followed by 8 CRC bits, MSB first. It recomputes CRC-8 over the payload with polynomial x^8+x^7+x^4+x^3+x+1 (0x9B), compares the result with the received CRC byte, and reports pass or fail with the recovered payload.

## Interface
- DATA_BITS, 32: payload length in bits. Must be ≥ 1.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  frame start strobe. Clears the CRC register, bit counter and flags, then enters DATA.
- DIN  input  1  serial data bit, MSB first.
- DIN_VALID  input  1  DIN is sampled only on edges where this is 1 and the state is DATA or CRC.
- BUSY  output  1  high in DATA and CRC states.
- DONE  output  1  single-cycle pulse when the frame check completes.
- CRC_OK  output  1  set at frame completion when received CRC equals computed CRC.
- CRC_ERR  output  1  set at frame completion on mismatch. Never high together with CRC_OK.
- DATA_OUT  output  DATA_BITS  deserialized payload. The first received bit lands in the MSB.
- CRC_CALC  output  8  computed CRC over the payload.
- CRC_RX  output  8  received CRC byte.

## Operation
- FSM states: IDLE, DATA, CRC, DONE.
- Reset: state IDLE. BUSY, DONE, CRC_OK and CRC_ERR are 0. DATA_OUT, CRC_CALC and CRC_RX are all zero.
- IDLE, START=1: on that edge, CRC register, CRC_RX, counter, CRC_OK and CRC_ERR are cleared, and the state goes to DATA. The bit on DIN in the START cycle is ignored.
- DATA, accepted bit d: fb = d ^ Q[7].
  - Q <= {Q[6]^fb, Q[5], Q[4], Q[3]^fb, Q[2]^fb, Q[1], Q[0]^fb, fb}. This is the direct, non-augmented form with initial value 0x00.
  - DATA_OUT <= {DATA_OUT[DATA_BITS-2:0], d}.
  - Counter increments. After DATA_BITS accepted bits, the counter resets and the state goes to CRC.
- CRC, accepted bit c: CRC_RX <= {CRC_RX[6:0], c}. The CRC register is frozen. After the 8th accepted bit the state goes to DONE.
- DONE (one cycle):
  - DONE=1.
  - CRC_OK = (CRC_RX == CRC_CALC), CRC_ERR = its inverse. Both are registered on entry to DONE.
  - Next state is IDLE.
- CRC_OK, CRC_ERR, DATA_OUT, CRC_CALC and CRC_RX hold their values in IDLE until the next START.
- CRC_CALC is the CRC register. It is visible live during DATA.
- DIN_VALID=0 in DATA or CRC: no state, counter or shift change. Gaps of any length are legal.
- START=1 in DATA or CRC aborts the frame and restarts as if from IDLE, with everything cleared. No DONE pulse is produced for the aborted frame.
- START=1 in DONE is ignored. DONE always completes.
- Counter width: $clog2(DATA_BITS+1), minimum 4 bits so it can count the 8 CRC bits.

## Timing
- Edge S samples START → BUSY=1 from after edge S.
- Minimum frame length, with no gaps: the last CRC bit is accepted at edge S+DATA_BITS+8.
- DONE, CRC_OK and CRC_ERR go high after that edge and are visible the next cycle.
- DONE deasserts, and BUSY is already 0, one edge later.
- Back-to-back frames: START is accepted in the first IDLE cycle after DONE.
- RST asserted mid-frame immediately forces the reset values listed above. No DONE pulse is produced.

## Test plan
- Reset mid-DATA, after 10 of 32 bits: all outputs return to zero and state is IDLE. A following START plus frame 0x00000000 with CRC 0x00 gives CRC_OK=1.
- Payload 0x00000001, CRC 0x9B, contiguous bits → DONE at cycle S+41, CRC_CALC=0x9B, CRC_OK=1, CRC_ERR=0, DATA_OUT=0x00000001.
- Payload 0x00000080, CRC 0x0B, with DIN_VALID low on every other cycle → CRC_OK=1, CRC_CALC=0x0B, BUSY held through all gaps.
- Payload 0x00000001 with received CRC 0x9A (single-bit error) → CRC_ERR=1, CRC_OK=0, CRC_RX=0x9A, CRC_CALC=0x9B.
- START reasserted after 20 payload bits, then a full frame with payload 0x00000080 and CRC 0x0B → exactly one DONE pulse, CRC_OK=1, and no effect from the aborted bits.
- Two back-to-back frames with 0x00000001/0x9B and 0x00000080/0x0B → two DONE pulses, and CRC_OK holds 1 across the IDLE gap between them.
